// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the arbitrated register array.
package mem_arb_pkg;

  // Controller modes: normal arbitrated access, or the init fill pass.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_INIT = 1'b1
  } state_e;

  localparam int NUM_REQ    = 2;
  localparam int DEF_WIDTH  = 32;
  localparam int DEF_DEPTH  = 16;
  localparam int DEF_ADDR_W = 5;

  // Addresses are zero-extended to this width before the range check.
  localparam int MAX_ADDR_W = 32;

  // Valid addresses are 1..depth; the compare is unsigned.
  function automatic logic addr_ok(input logic [MAX_ADDR_W-1:0] addr,
                                   input int unsigned           depth);
    return (addr != '0) && (addr <= depth);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The grant is combinational; the flop
// remembers who won last so a tie goes to the other requester.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic               clk,
  input  logic               reset_l,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt
);

  // 1 = requester 1 was granted last, so requester 0 wins the next tie.
  logic r_last;

  // Pick the winner for this cycle; nothing is granted while disabled.
  always_comb begin
    // NOTE: assign a default before any branch so no path leaves gnt
    // unassigned, otherwise synthesis infers a latch.
    gnt = '0;
    if (en) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = r_last ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  // Priority pointer moves only when something was actually granted.
  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values; blocking here would create order-dependent races.
    if (!reset_l) begin
      r_last <= 1'b1;
    end else if (|gnt) begin
      r_last <= gnt[1];
    end
  end

endmodule

// File: rtl/mem_arb_ctrl.sv
// Register array shared by two round-robin requesters, with an init
// sequencer that fills mem[i] = i from the top entry down to entry 1.
module mem_arb_ctrl
  import mem_arb_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                       clk,
  input  logic                       reset_l,
  input  logic                       init_start,
  output logic                       init_busy,
  output logic                       init_done,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ-1:0]         req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [WIDTH-1:0]           rsp_rdata,
  output logic                       rsp_err
);

  // Array storage; index 0 is never used.
  logic [WIDTH-1:0]   r_mem [1:DEPTH];

  // Sequencer state and registered init status.
  state_e             r_state;
  logic [ADDR_W-1:0]  r_ptr;
  logic               r_init_busy;
  logic               r_init_done;

  // Response pipe, one cycle behind the grant.
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic [WIDTH-1:0]   r_rsp_rdata;
  logic               r_rsp_err;

  // Selected access for this cycle.
  logic               w_arb_en;
  logic [NUM_REQ-1:0] w_gnt;
  logic               w_acc;
  logic               w_sel;
  logic               w_we;
  logic [ADDR_W-1:0]  w_addr;
  logic [WIDTH-1:0]   w_wdata;
  logic               w_addr_ok;

  // A fresh init request takes the cycle, so requests wait even in IDLE.
  assign w_arb_en = (r_state == ST_IDLE) && !init_start;

  rr_arb2 u_arb (
    .clk     (clk),
    .reset_l (reset_l),
    .req     (req_valid),
    .en      (w_arb_en),
    .gnt     (w_gnt)
  );

  assign w_acc     = |w_gnt;
  assign w_sel     = w_gnt[1];
  assign w_we      = req_we[w_sel];
  assign w_addr    = w_sel ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
  assign w_wdata   = w_sel ? req_wdata[2*WIDTH-1:WIDTH] : req_wdata[WIDTH-1:0];
  assign w_addr_ok = addr_ok(MAX_ADDR_W'(w_addr), DEPTH);

  // Init sequencer: load the pointer, count it down to 1, then pulse done.
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_init_busy <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      r_init_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (init_start) begin
            r_state     <= ST_INIT;
            r_ptr       <= ADDR_W'(DEPTH);
            r_init_busy <= 1'b1;
          end
        end
        ST_INIT: begin
          r_ptr <= r_ptr - ADDR_W'(1);
          if (r_ptr == ADDR_W'(1)) begin
            r_state     <= ST_IDLE;
            r_init_busy <= 1'b0;
            r_init_done <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Array write port: fill writes in INIT, granted in-range writes in IDLE.
  always_ff @(posedge clk) begin
    // NOTE: the array deliberately has no reset; contents survive reset and
    // a reset-capable memory would not map onto RAM resources.
    if (r_state == ST_INIT) begin
      r_mem[r_ptr] <= WIDTH'(r_ptr);
    end else if (w_acc && w_we && w_addr_ok) begin
      r_mem[w_addr] <= w_wdata;
    end
  end

  // Response pipe: strobe the winner, return read data or flag a bad address.
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= w_gnt;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      if (w_acc) begin
        if (!w_addr_ok) begin
          r_rsp_err <= 1'b1;
        end else if (!w_we) begin
          r_rsp_rdata <= r_mem[w_addr];
        end
      end
    end
  end

  assign req_ready = w_gnt;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign init_busy = r_init_busy;
  assign init_done = r_init_done;

endmodule

// File: tb/tb_mem_arb_ctrl.sv
// Bench for mem_arb_ctrl: directed scenarios with literal expectations,
// plus a cycle-level behavioural model compared on every falling edge.
module tb_mem_arb_ctrl;

  localparam int WIDTH  = 32;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 5;

  logic                clk = 1'b0;
  logic                reset_l;
  logic                init_start;
  logic                init_busy;
  logic                init_done;
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [1:0]          req_we;
  logic [2*ADDR_W-1:0] req_addr;
  logic [2*WIDTH-1:0]  req_wdata;
  logic [1:0]          rsp_valid;
  logic [WIDTH-1:0]    rsp_rdata;
  logic                rsp_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_arb_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset_l    (reset_l),
    .init_start (init_start),
    .init_busy  (init_busy),
    .init_done  (init_done),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  // Fill progress is tracked as "fill writes still to do"; since the fill
  // walks downward ending at 1, that count is also the next address filled.
  logic [WIDTH-1:0] m_mem   [1:DEPTH];
  bit               m_known [1:DEPTH];
  int               m_fill_left = 0;
  bit               m_done      = 0;
  int               m_last      = 1;
  bit               m_synced    = 0;
  logic [1:0]       m_rsp_vld   = 2'b00;
  logic [WIDTH-1:0] m_rsp_rdata = '0;
  bit               m_rsp_err   = 0;
  bit               m_rsp_known = 1;

  always @(negedge clk) begin : model
    logic [1:0]       g;
    int               w;
    int               a;
    bit               we;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] nrd;
    bit               nerr;
    bit               nknown;

    // Who should be granted this cycle.
    g = 2'b00;
    if (m_fill_left == 0 && !init_start) begin
      if (req_valid == 2'b01)      g = 2'b01;
      else if (req_valid == 2'b10) g = 2'b10;
      else if (req_valid == 2'b11) g = (m_last == 0) ? 2'b10 : 2'b01;
    end

    if (m_synced) begin
      check("req_ready", req_ready, g);
      check("rsp_valid", rsp_valid, m_rsp_vld);
      check("rsp_err", rsp_err, m_rsp_err);
      if (m_rsp_known) check("rsp_rdata", rsp_rdata, m_rsp_rdata);
      check("init_busy", init_busy, m_fill_left > 0);
      check("init_done", init_done, m_done);
    end

    w  = (g == 2'b10) ? 1 : 0;
    a  = (w == 1) ? int'(req_addr[2*ADDR_W-1:ADDR_W]) : int'(req_addr[ADDR_W-1:0]);
    we = req_we[w];
    wd = (w == 1) ? req_wdata[2*WIDTH-1:WIDTH] : req_wdata[WIDTH-1:0];

    nrd = '0; nerr = 0; nknown = 1;
    if (g != 2'b00) begin
      if (a < 1 || a > DEPTH) nerr = 1;
      else if (!we) begin
        nrd    = m_mem[a];
        nknown = m_known[a];
      end
    end

    // Array contents are never affected by reset.
    if (m_fill_left > 0) begin
      m_mem[m_fill_left]   = WIDTH'(m_fill_left);
      m_known[m_fill_left] = 1;
    end else if (g != 2'b00 && we && a >= 1 && a <= DEPTH) begin
      m_mem[a]   = wd;
      m_known[a] = 1;
    end

    if (!reset_l) begin
      m_fill_left = 0;
      m_done      = 0;
      m_last      = 1;
      m_rsp_vld   = 2'b00;
      m_rsp_rdata = '0;
      m_rsp_err   = 0;
      m_rsp_known = 1;
      m_synced    = 1;
    end else begin
      m_done = (m_fill_left == 1);
      if (m_fill_left > 0) m_fill_left--;
      else if (init_start) m_fill_left = DEPTH;
      if (g != 2'b00) m_last = w;
      m_rsp_vld   = g;
      m_rsp_rdata = nrd;
      m_rsp_err   = nerr;
      m_rsp_known = nknown;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: time limit reached, got timeout, expected finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int busy_cnt;
    int done_cnt;
    int done_cyc;

    reset_l = 1'b0; init_start = 1'b0;
    req_valid = 2'b00; req_we = 2'b00; req_addr = '0; req_wdata = '0;
    repeat (2) tick();
    reset_l = 1'b1;
    #1;
    check("reset_init_busy", init_busy, 1'b0);
    check("reset_init_done", init_done, 1'b0);
    check("reset_rsp_valid", rsp_valid, 2'b00);
    check("reset_rsp_rdata", rsp_rdata, 32'h0);
    check("reset_rsp_err", rsp_err, 1'b0);

    // Init fill: busy for 16 cycles, done in cycle 17.
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    busy_cnt = 0; done_cnt = 0; done_cyc = -1;
    for (int c = 1; c <= 30; c++) begin
      #1;
      if (init_busy === 1'b1) busy_cnt++;
      if (init_done === 1'b1) begin
        done_cnt++;
        done_cyc = c;
      end
      tick();
    end
    check("init_busy_cycles", 64'(busy_cnt), 64'd16);
    check("init_done_cycle", 64'(done_cyc), 64'd17);
    check("init_done_pulses", 64'(done_cnt), 64'd1);
    for (int i = DEPTH; i >= 1; i--) check("mem_after_init", dut.r_mem[i], 64'(i));

    // Write then back-to-back read of the same address.
    req_valid = 2'b01; req_we = 2'b01;
    req_addr[ADDR_W-1:0] = 5'd5; req_wdata[WIDTH-1:0] = 32'hDEADBEEF;
    #1 check("wr_grant_r0", req_ready, 2'b01);
    tick();
    req_valid = 2'b10; req_we = 2'b00; req_addr[2*ADDR_W-1:ADDR_W] = 5'd5;
    #1 check("rd_grant_r1", req_ready, 2'b10);
    check("wr_ack_valid", rsp_valid, 2'b01);
    check("wr_ack_rdata", rsp_rdata, 32'h0);
    tick();
    req_valid = 2'b00;
    #1 check("rd_rsp_valid", rsp_valid, 2'b10);
    check("rd_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
    check("rd_rsp_err", rsp_err, 1'b0);

    // Both requesters hold reads: grants alternate starting with 0.
    req_valid = 2'b11; req_we = 2'b00;
    req_addr = {5'd4, 5'd3};
    for (int i = 0; i < 6; i++) begin
      #1 check("alt_grant", req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
      if (i > 0) check("alt_rsp_follows", rsp_valid, (i % 2 == 0) ? 2'b10 : 2'b01);
      tick();
    end
    req_valid = 2'b00;
    #1 check("alt_last_rsp", rsp_valid, 2'b10);
    check("alt_last_rdata", rsp_rdata, 32'd4);

    // Out-of-range addresses: 0 and 17 read, 0 written.
    req_valid = 2'b01; req_we = 2'b00; req_addr[ADDR_W-1:0] = 5'd0;
    #1 check("oor0_grant", req_ready, 2'b01);
    tick();
    req_valid = 2'b10; req_we = 2'b00; req_addr[2*ADDR_W-1:ADDR_W] = 5'd17;
    #1 check("oor0_err", rsp_err, 1'b1);
    check("oor0_rdata", rsp_rdata, 32'h0);
    tick();
    req_valid = 2'b01; req_we = 2'b01; req_addr[ADDR_W-1:0] = 5'd0;
    req_wdata[WIDTH-1:0] = 32'h12345678;
    #1 check("oor17_valid", rsp_valid, 2'b10);
    check("oor17_err", rsp_err, 1'b1);
    check("oor17_rdata", rsp_rdata, 32'h0);
    tick();
    req_valid = 2'b01; req_we = 2'b00; req_addr[ADDR_W-1:0] = 5'd16;
    #1 check("oor_wr_err", rsp_err, 1'b1);
    tick();
    req_valid = 2'b00;
    #1 check("mem16_read", rsp_rdata, 32'd16);
    check("mem16_err", rsp_err, 1'b0);
    check("mem16_direct", dut.r_mem[16], 32'd16);

    // Reset so requester 0 holds the tie priority.
    reset_l = 1'b0;
    tick();
    reset_l = 1'b1;

    // init_start together with both requests: no grant for 17 cycles.
    init_start = 1'b1; req_valid = 2'b11; req_we = 2'b00;
    req_addr = {5'd3, 5'd2};
    for (int c = 0; c <= 16; c++) begin
      #1 check("init_blocks_grant", req_ready, 2'b00);
      tick();
      if (c == 0) init_start = 1'b0;
    end
    #1 check("first_grant_after_init", req_ready, 2'b01);
    tick();
    #1 check("second_grant_after_init", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;

    // Preload 1..8 with all-ones, then abort a fill at cycle 8.
    for (int a = 1; a <= 8; a++) begin
      req_valid = 2'b01; req_we = 2'b01;
      req_addr[ADDR_W-1:0] = 5'(a); req_wdata[WIDTH-1:0] = 32'hFFFFFFFF;
      tick();
    end
    req_valid = 2'b00; req_we = 2'b00;
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    repeat (7) tick();
    reset_l = 1'b0;
    tick();
    reset_l = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      #1 if (init_done === 1'b1) done_cnt++;
      tick();
    end
    check("abort_no_done", 64'(done_cnt), 64'd0);
    check("abort_busy_low", init_busy, 1'b0);
    for (int i = DEPTH; i >= 9; i--) check("abort_mem_filled", dut.r_mem[i], 64'(i));
    for (int i = 8; i >= 1; i--) check("abort_mem_kept", dut.r_mem[i], 32'hFFFFFFFF);

    // Reset right after a grant drops the response.
    req_valid = 2'b01; req_we = 2'b00; req_addr[ADDR_W-1:0] = 5'd16;
    reset_l = 1'b0;
    tick();
    reset_l = 1'b1; req_valid = 2'b00;
    #1 check("reset_drops_rsp", rsp_valid, 2'b00);
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    #1 check("post_reset_rsp", rsp_valid, 2'b01);
    check("post_reset_rdata", rsp_rdata, 32'd16);

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
